// File: rtl/graph_stream_reader.sv
// Multi-channel AXI read streamer: issues credit-limited, 4KB-safe bursts per channel
// for a configurable number of rounds and hands the returned beats out per-channel FIFOs.
module graph_stream_reader #(
    parameter int N_CH      = 2,
    parameter int LOG_DEPTH = 4,
    parameter int MAX_BURST = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [N_CH*64-1:0]   cfg_base,
    input  logic [N_CH*32-1:0]   cfg_beats,
    input  logic [15:0]          cfg_rounds,
    output logic                 busy,
    output logic                 done,
    output logic [15:0]          arid_m,
    output logic [63:0]          araddr_m,
    output logic [7:0]           arlen_m,
    output logic [2:0]           arsize_m,
    output logic                 arvalid_m,
    input  logic                 arready_m,
    input  logic [15:0]          rid_m,
    input  logic [511:0]         rdata_m,
    input  logic [1:0]           rresp_m,
    input  logic                 rlast_m,
    input  logic                 rvalid_m,
    output logic                 rready_m,
    output logic [N_CH-1:0]      out_valid,
    output logic [N_CH*512-1:0]  out_data,
    input  logic [N_CH-1:0]      out_ready
);
    localparam int DEPTH = 1 << LOG_DEPTH;
    localparam int CW    = LOG_DEPTH + 2;
    localparam int IW    = (N_CH > 1) ? $clog2(N_CH) : 1;

    typedef enum logic [1:0] {IDLE, RUN, NEXT_ROUND, FINISH} state_t;

    state_t               state_q, state_d;
    logic [63:0]          base_q   [N_CH], base_d  [N_CH];
    logic [31:0]          beats_q  [N_CH], beats_d [N_CH];
    logic [15:0]          rounds_q, rounds_d, round_q, round_d;
    logic [63:0]          addr_q   [N_CH], addr_d  [N_CH];
    logic [31:0]          rem_q    [N_CH], rem_d   [N_CH];
    logic [CW-1:0]        outst_q  [N_CH], outst_d [N_CH];
    logic [CW-1:0]        cnt_q    [N_CH], cnt_d   [N_CH];
    logic [LOG_DEPTH-1:0] wp_q     [N_CH], wp_d    [N_CH];
    logic [LOG_DEPTH-1:0] rp_q     [N_CH], rp_d    [N_CH];
    logic [IW-1:0]        rr_q, rr_d;
    logic                 arvalid_q, arvalid_d;
    logic [63:0]          araddr_q, araddr_d;
    logic [7:0]           arlen_q, arlen_d;
    logic [15:0]          arid_q, arid_d;
    logic                 busy_q, busy_d, done_q, done_d;
    logic [511:0]         mem_q [N_CH][DEPTH];

    logic [31:0]          burst_len [N_CH];
    logic [N_CH-1:0]      eligible, issue_c, beat_c, pop_c;
    logic                 grant_vld, ar_hs, all_idle;
    logic [IW-1:0]        grant_idx;
    logic [CW-1:0]        ar_beats;
    logic [16:0]          rounds_eff;
    logic                 unused_r;

    assign unused_r = ^{rresp_m, rlast_m};

    // Burst sizing, credit check and round-robin pick starting after the last grant.
    always_comb begin
        int idx;
        for (int c = 0; c < N_CH; c++) begin
            burst_len[c] = 32'(MAX_BURST);
            if (rem_q[c] < burst_len[c]) burst_len[c] = rem_q[c];
            if ((32'd64 - 32'(addr_q[c][11:6])) < burst_len[c])
                burst_len[c] = 32'd64 - 32'(addr_q[c][11:6]);
            eligible[c] = (rem_q[c] != 32'd0) &&
                          ((32'(DEPTH) - 32'(cnt_q[c]) - 32'(outst_q[c])) >= burst_len[c]);
        end
        grant_vld = 1'b0;
        grant_idx = '0;
        for (int k = N_CH - 1; k >= 0; k--) begin
            idx = (int'(rr_q) + k) % N_CH;
            if (eligible[idx]) begin
                grant_vld = 1'b1;
                grant_idx = IW'(idx);
            end
        end
    end

    always_comb begin
        ar_hs    = arvalid_q && arready_m;
        ar_beats = CW'(arlen_q) + CW'(1);
        for (int c = 0; c < N_CH; c++) begin
            issue_c[c] = ar_hs && (arid_q == 16'(c));
            beat_c[c]  = rvalid_m && (state_q != IDLE) && (rid_m == 16'(c)) && (outst_q[c] != '0);
            pop_c[c]   = out_valid[c] && out_ready[c];
        end
    end

    always_comb begin
        state_d   = state_q;
        base_d    = base_q;
        beats_d   = beats_q;
        rounds_d  = rounds_q;
        round_d   = round_q;
        addr_d    = addr_q;
        rem_d     = rem_q;
        outst_d   = outst_q;
        cnt_d     = cnt_q;
        wp_d      = wp_q;
        rp_d      = rp_q;
        rr_d      = rr_q;
        arvalid_d = arvalid_q && !ar_hs;
        araddr_d  = araddr_q;
        arlen_d   = arlen_q;
        arid_d    = arid_q;
        all_idle  = !arvalid_q;
        rounds_eff = (rounds_q == 16'd0) ? 17'd1 : 17'(rounds_q);

        for (int c = 0; c < N_CH; c++) begin
            outst_d[c] = outst_q[c] + (issue_c[c] ? ar_beats : '0) - (beat_c[c] ? CW'(1) : '0);
            cnt_d[c]   = cnt_q[c] + CW'(beat_c[c]) - CW'(pop_c[c]);
            if (beat_c[c]) wp_d[c] = wp_q[c] + 1'b1;
            if (pop_c[c])  rp_d[c] = rp_q[c] + 1'b1;
            if (issue_c[c]) begin
                addr_d[c] = addr_q[c] + (64'(ar_beats) << 6);
                rem_d[c]  = rem_q[c] - 32'(ar_beats);
            end
            if (rem_q[c] != 32'd0 || outst_q[c] != '0 || cnt_q[c] != '0) all_idle = 1'b0;
        end

        case (state_q)
            IDLE: if (start) begin
                state_d  = RUN;
                rounds_d = cfg_rounds;
                round_d  = 16'd0;
                for (int c = 0; c < N_CH; c++) begin
                    base_d[c]  = cfg_base[64*c +: 64];
                    beats_d[c] = cfg_beats[32*c +: 32];
                    addr_d[c]  = cfg_base[64*c +: 64];
                    rem_d[c]   = cfg_beats[32*c +: 32];
                end
            end
            RUN: begin
                if (!arvalid_q && grant_vld) begin
                    arvalid_d = 1'b1;
                    araddr_d  = addr_q[grant_idx];
                    arlen_d   = 8'(burst_len[grant_idx] - 32'd1);
                    arid_d    = 16'(grant_idx);
                    rr_d      = (int'(grant_idx) == N_CH - 1) ? '0 : grant_idx + 1'b1;
                end else if (all_idle) begin
                    state_d = NEXT_ROUND;
                end
            end
            NEXT_ROUND: begin
                if ((17'(round_q) + 17'd1) < rounds_eff) begin
                    state_d = RUN;
                    round_d = round_q + 16'd1;
                    for (int c = 0; c < N_CH; c++) begin
                        addr_d[c] = base_q[c];
                        rem_d[c]  = beats_q[c];
                    end
                end else begin
                    state_d = FINISH;
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
        done_d = (state_d == FINISH);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            rounds_q  <= '0;
            round_q   <= '0;
            rr_q      <= '0;
            arvalid_q <= 1'b0;
            araddr_q  <= '0;
            arlen_q   <= '0;
            arid_q    <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            for (int c = 0; c < N_CH; c++) begin
                base_q[c]  <= '0;
                beats_q[c] <= '0;
                addr_q[c]  <= '0;
                rem_q[c]   <= '0;
                outst_q[c] <= '0;
                cnt_q[c]   <= '0;
                wp_q[c]    <= '0;
                rp_q[c]    <= '0;
            end
        end else begin
            state_q   <= state_d;
            base_q    <= base_d;
            beats_q   <= beats_d;
            rounds_q  <= rounds_d;
            round_q   <= round_d;
            addr_q    <= addr_d;
            rem_q     <= rem_d;
            outst_q   <= outst_d;
            cnt_q     <= cnt_d;
            wp_q      <= wp_d;
            rp_q      <= rp_d;
            rr_q      <= rr_d;
            arvalid_q <= arvalid_d;
            araddr_q  <= araddr_d;
            arlen_q   <= arlen_d;
            arid_q    <= arid_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    // Beat storage needs no reset: occupancy is governed by the pointers and counts.
    always_ff @(posedge clk) begin
        for (int c = 0; c < N_CH; c++)
            if (beat_c[c]) mem_q[c][wp_q[c]] <= rdata_m;
    end

    for (genvar c = 0; c < N_CH; c++) begin : g_out
        assign out_valid[c]           = (cnt_q[c] != '0);
        assign out_data[c*512 +: 512] = mem_q[c][rp_q[c]];
    end

    assign arvalid_m = arvalid_q;
    assign araddr_m  = araddr_q;
    assign arlen_m   = arlen_q;
    assign arid_m    = arid_q;
    assign arsize_m  = 3'b110;
    assign rready_m  = 1'b1;
    assign busy      = busy_q;
    assign done      = done_q;
endmodule

// File: tb/tb_graph_stream_reader.sv
// Randomized bench for graph_stream_reader: an AXI memory responder plus a per-channel
// model of expected burst addresses/lengths, credit limits and delivered beat order.
module tb_graph_stream_reader;
    localparam int N_CH      = 2;
    localparam int LOG_DEPTH = 4;
    localparam int MAX_BURST = 8;
    localparam int DEPTH     = 1 << LOG_DEPTH;

    logic                clk = 1'b0;
    logic                rst;
    logic                start;
    logic [N_CH*64-1:0]  cfg_base;
    logic [N_CH*32-1:0]  cfg_beats;
    logic [15:0]         cfg_rounds;
    logic                busy, done;
    logic [15:0]         arid_m;
    logic [63:0]         araddr_m;
    logic [7:0]          arlen_m;
    logic [2:0]          arsize_m;
    logic                arvalid_m, arready_m;
    logic [15:0]         rid_m;
    logic [511:0]        rdata_m;
    logic [1:0]          rresp_m;
    logic                rlast_m, rvalid_m, rready_m;
    logic [N_CH-1:0]     out_valid;
    logic [N_CH*512-1:0] out_data;
    logic [N_CH-1:0]     out_ready;

    always #5 clk = ~clk;

    graph_stream_reader #(.N_CH(N_CH), .LOG_DEPTH(LOG_DEPTH), .MAX_BURST(MAX_BURST)) dut (
        .clk(clk), .rst(rst), .start(start),
        .cfg_base(cfg_base), .cfg_beats(cfg_beats), .cfg_rounds(cfg_rounds),
        .busy(busy), .done(done),
        .arid_m(arid_m), .araddr_m(araddr_m), .arlen_m(arlen_m), .arsize_m(arsize_m),
        .arvalid_m(arvalid_m), .arready_m(arready_m),
        .rid_m(rid_m), .rdata_m(rdata_m), .rresp_m(rresp_m), .rlast_m(rlast_m),
        .rvalid_m(rvalid_m), .rready_m(rready_m),
        .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready)
    );

    typedef struct { int id; logic [63:0] addr; int len; } burst_t;

    burst_t      rsp_q[$];
    int          rsp_beat;
    logic [63:0] exp_q     [N_CH][$];
    logic [63:0] ar_addr_q [N_CH][$];
    int          ar_left_q [N_CH][$];
    int          m_out [N_CH];
    int          m_occ [N_CH];
    int          ar_ids[$];
    int          ch0_req, done_cnt, pop_cnt;
    int          pass_cnt = 0;
    int          check_cnt = 0;

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        check_cnt++;
        if (got === exp) pass_cnt++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    // Memory content is a pure function of address and channel, so order errors show up as data errors.
    function automatic logic [511:0] dataFor(input logic [63:0] a, input int ch);
        logic [511:0] d;
        for (int k = 0; k < 8; k++) d[k*64 +: 64] = a ^ (64'(ch + 1) << 56) ^ (64'(k) << 48);
        return d;
    endfunction

    task automatic clearModel();
        for (int c = 0; c < N_CH; c++) begin
            exp_q[c].delete();
            ar_addr_q[c].delete();
            ar_left_q[c].delete();
            m_out[c] = 0;
            m_occ[c] = 0;
        end
        rsp_q.delete();
        rsp_beat = 0;
        ar_ids.delete();
        ch0_req  = 0;
        done_cnt = 0;
        pop_cnt  = 0;
    endtask

    task automatic launchRun(input logic [63:0] b0, input logic [63:0] b1,
                             input int n0, input int n1, input int rounds);
        logic [63:0] base [N_CH];
        int          beats [N_CH];
        int          nr;
        clearModel();
        base[0] = b0; base[1] = b1; beats[0] = n0; beats[1] = n1;
        nr = (rounds == 0) ? 1 : rounds;
        for (int r = 0; r < nr; r++)
            for (int c = 0; c < N_CH; c++)
                for (int i = 0; i < beats[c]; i++) begin
                    exp_q[c].push_back(base[c] + 64'(i * 64));
                    ar_addr_q[c].push_back(base[c] + 64'(i * 64));
                    ar_left_q[c].push_back(beats[c] - i);
                end
        @(negedge clk);
        cfg_base   = {b1, b0};
        cfg_beats  = {32'(n1), 32'(n0)};
        cfg_rounds = 16'(rounds);
        start      = 1'b1;
        arready_m  = 1'b0;
        rvalid_m   = 1'b0;
        out_ready  = '0;
    endtask

    // One clock: check outputs at the falling edge, drive inputs, and advance the model
    // by the handshakes that the next rising edge will complete.
    task automatic cycleStep(input int pr_ar, input int pr_r, input int pr_pop, input bit hold0);
        int          c, len, exp_len, id;
        logic [63:0] a;
        logic [511:0] got;
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < N_CH; k++)
            checkOutput("out_valid", 64'(out_valid[k]), 64'(m_occ[k] > 0));
        if (done) done_cnt++;

        arready_m = ($urandom_range(99) < pr_ar);
        for (int k = 0; k < N_CH; k++)
            out_ready[k] = ($urandom_range(99) < pr_pop) && !(hold0 && k == 0);

        if (arvalid_m && arready_m) begin
            c   = int'(arid_m);
            len = int'(arlen_m) + 1;
            checkOutput("arid_range", 64'(c < N_CH), 64'd1);
            checkOutput("arsize", 64'(arsize_m), 64'd6);
            if (c < N_CH) begin
                checkOutput("ar_expected", 64'(ar_addr_q[c].size() >= len), 64'd1);
                checkOutput("ar_credit", 64'(m_out[c] + m_occ[c] + len <= DEPTH), 64'd1);
                if (ar_addr_q[c].size() > 0) begin
                    a = ar_addr_q[c][0];
                    exp_len = MAX_BURST;
                    if (ar_left_q[c][0] < exp_len) exp_len = ar_left_q[c][0];
                    if (64 - int'(a[11:6]) < exp_len) exp_len = 64 - int'(a[11:6]);
                    checkOutput("araddr", araddr_m, a);
                    checkOutput("arlen", 64'(arlen_m), 64'(exp_len - 1));
                    for (int k = 0; k < len; k++)
                        if (ar_addr_q[c].size() > 0) begin
                            void'(ar_addr_q[c].pop_front());
                            void'(ar_left_q[c].pop_front());
                        end
                end
            end
        end

        for (int k = 0; k < N_CH; k++)
            if (out_valid[k] && out_ready[k]) begin
                got = out_data[k*512 +: 512];
                checkOutput("pop_expected", 64'(exp_q[k].size() > 0), 64'd1);
                if (exp_q[k].size() > 0) begin
                    a = exp_q[k].pop_front();
                    checkOutput("out_data", 64'(got == dataFor(a, k)), 64'd1);
                end
                m_occ[k]--;
                pop_cnt++;
            end

        rvalid_m = 1'b0; rid_m = '0; rlast_m = 1'b0; rdata_m = '0;
        rresp_m  = 2'($urandom_range(3));
        if (rsp_q.size() > 0 && $urandom_range(99) < pr_r) begin
            id       = rsp_q[0].id;
            rvalid_m = 1'b1;
            rid_m    = 16'(id);
            rdata_m  = dataFor(rsp_q[0].addr + 64'(rsp_beat * 64), id);
            rlast_m  = (rsp_beat == rsp_q[0].len - 1);
            m_out[id]--;
            m_occ[id]++;
            rsp_beat++;
            if (rsp_beat == rsp_q[0].len) begin
                void'(rsp_q.pop_front());
                rsp_beat = 0;
            end
        end else if ($urandom_range(99) < 5) begin
            rvalid_m = 1'b1;
            rid_m    = 16'd5;
            rlast_m  = 1'b1;
            rdata_m  = {8{64'hDEAD_BEEF_0BAD_F00D}};
        end

        if (arvalid_m && arready_m && int'(arid_m) < N_CH) begin
            c   = int'(arid_m);
            len = int'(arlen_m) + 1;
            m_out[c] += len;
            rsp_q.push_back('{id: c, addr: araddr_m, len: len});
            ar_ids.push_back(c);
            if (c == 0) ch0_req += len;
        end
    endtask

    task automatic applyStimulus(input logic [63:0] b0, input logic [63:0] b1, input int n0,
                                 input int n1, input int rounds, input int pr_ar, input int pr_r,
                                 input int pr_pop, input int hold);
        int cyc, nr;
        nr = (rounds == 0) ? 1 : rounds;
        launchRun(b0, b1, n0, n1, rounds);
        cycleStep(pr_ar, pr_r, pr_pop, hold > 0);
        checkOutput("busy_running", 64'(busy), 64'd1);
        cyc = 1;
        while (done_cnt == 0 && cyc < 6000) begin
            cycleStep(pr_ar, pr_r, pr_pop, cyc < hold);
            cyc++;
            if (hold > 0 && cyc == hold) checkOutput("hold_ch0_req", 64'(ch0_req), 64'(DEPTH));
        end
        repeat (3) cycleStep(pr_ar, pr_r, pr_pop, 1'b0);
        checkOutput("done_once", 64'(done_cnt), 64'd1);
        checkOutput("busy_after", 64'(busy), 64'd0);
        checkOutput("beats_out", 64'(pop_cnt), 64'(nr * (n0 + n1)));
        for (int c = 0; c < N_CH; c++)
            checkOutput("exp_drained", 64'(exp_q[c].size()), 64'd0);
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int cyc;
        logic [63:0] rb0, rb1;
        rst = 1'b1; start = 1'b0; cfg_base = '0; cfg_beats = '0; cfg_rounds = '0;
        arready_m = 1'b0; rid_m = '0; rdata_m = '0; rresp_m = '0; rlast_m = 1'b0;
        rvalid_m = 1'b0; out_ready = '0;
        clearModel();
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        @(negedge clk);
        checkOutput("rst_arvalid", 64'(arvalid_m), 64'd0);
        checkOutput("rst_araddr", araddr_m, 64'd0);
        checkOutput("rst_arlen", 64'(arlen_m), 64'd0);
        checkOutput("rst_arid", 64'(arid_m), 64'd0);
        checkOutput("rst_arsize", 64'(arsize_m), 64'd6);
        checkOutput("rst_busy", 64'(busy), 64'd0);
        checkOutput("rst_done", 64'(done), 64'd0);
        checkOutput("rst_out_valid", 64'(out_valid), 64'd0);
        checkOutput("rready", 64'(rready_m), 64'd1);

        $display("[TB] two-channel interleave with full-rate handshakes");
        applyStimulus(64'h0, 64'h1000, 20, 5, 1, 100, 100, 100, 0);
        checkOutput("rr_count", 64'(ar_ids.size()), 64'd4);
        if (ar_ids.size() == 4) begin
            checkOutput("rr_0", 64'(ar_ids[0]), 64'd0);
            checkOutput("rr_1", 64'(ar_ids[1]), 64'd1);
            checkOutput("rr_2", 64'(ar_ids[2]), 64'd0);
            checkOutput("rr_3", 64'(ar_ids[3]), 64'd0);
        end

        $display("[TB] 4KB boundary split");
        applyStimulus(64'hFC0, 64'h2000, 4, 0, 1, 100, 100, 100, 0);
        checkOutput("split_bursts", 64'(ar_ids.size()), 64'd2);

        $display("[TB] back-pressure on channel 0");
        applyStimulus(64'h0, 64'h8000, 40, 0, 1, 100, 100, 100, 150);

        $display("[TB] three rounds replay");
        applyStimulus(64'h3000, 64'h5000, 2, 2, 3, 80, 80, 80, 0);

        $display("[TB] all-zero config");
        applyStimulus(64'h0, 64'h0, 0, 0, 2, 100, 100, 100, 0);
        checkOutput("zero_no_ar", 64'(ar_ids.size()), 64'd0);

        $display("[TB] reset with bursts outstanding");
        launchRun(64'h0, 64'h4000, 20, 20, 1);
        cyc = 0;
        while (m_out[0] + m_out[1] < 6 && cyc < 200) begin
            cycleStep(100, 0, 100, 1'b0);
            cyc++;
        end
        checkOutput("outstanding_pre_rst", 64'(m_out[0] + m_out[1] >= 6), 64'd1);
        @(posedge clk);
        #2 rst = 1'b1;
        @(negedge clk);
        checkOutput("midrst_arvalid", 64'(arvalid_m), 64'd0);
        checkOutput("midrst_out_valid", 64'(out_valid), 64'd0);
        checkOutput("midrst_busy", 64'(busy), 64'd0);
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            rvalid_m = 1'b1;
            rid_m    = 16'(k % 2);
            rdata_m  = '1;
            @(negedge clk);
            checkOutput("stale_drop", 64'(out_valid), 64'd0);
        end
        rvalid_m = 1'b0;
        clearModel();
        applyStimulus(64'h7000, 64'h9FC0, 12, 9, 1, 70, 70, 70, 0);

        $display("[TB] randomized runs");
        for (int t = 0; t < 6; t++) begin
            rb0 = (64'($urandom_range(15)) << 12) | (64'($urandom_range(1) ? $urandom_range(48, 63) : $urandom_range(63)) << 6);
            rb1 = 64'h10_0000 | (64'($urandom_range(15)) << 12) | (64'($urandom_range(63)) << 6);
            applyStimulus(rb0, rb1, $urandom_range(40), $urandom_range(40), $urandom_range(3),
                          $urandom_range(30, 100), $urandom_range(30, 100), $urandom_range(30, 100), 0);
        end

        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end
endmodule

// File: doc/graph_stream_reader.md
GRAPH_STREAM_READER -- requirements
Module: graph_stream_reader

Interface
REQ-001 SHALL have parameter N_CH, default 2: number of independent read channels (vertex, in-edge, ...), 1..8.
REQ-002 SHALL have parameter LOG_DEPTH, default 4: log2 of per-channel beat FIFO depth.
REQ-003 SHALL have parameter MAX_BURST, default 8: max beats per AXI burst, 1..2^LOG_DEPTH.
REQ-004 SHALL have ports clk (in, 1, clock) and rst (in, 1); reset is asynchronous and active-high.
REQ-005 SHALL have port start (in, 1): launch request, sampled in IDLE only.
REQ-006 SHALL have port cfg_base (in, N_CH*64): per-channel byte base address, 64B aligned; channel c at bits [64c+63:64c].
REQ-007 SHALL have port cfg_beats (in, N_CH*32): per-channel 512-bit beats per round.
REQ-008 SHALL have port cfg_rounds (in, 16): rounds to run; 0 treated as 1.
REQ-009 SHALL have ports busy (out, 1) and done (out, 1, one-cycle pulse).
REQ-010 SHALL have AXI AR ports arid_m (out, 16), araddr_m (out, 64), arlen_m (out, 8), arsize_m (out, 3), arvalid_m (out, 1), arready_m (in, 1).
REQ-011 SHALL have AXI R ports rid_m (in, 16), rdata_m (in, 512), rresp_m (in, 2), rlast_m (in, 1), rvalid_m (in, 1), rready_m (out, 1).
REQ-012 SHALL have per-channel stream ports out_valid (out, N_CH), out_data (out, N_CH*512), out_ready (in, N_CH).

Function
REQ-013 SHALL implement states IDLE, RUN, NEXT_ROUND, FINISH; IDLE->RUN on start; RUN->NEXT_ROUND when all channels idle (remaining 0, outstanding 0, FIFO empty); NEXT_ROUND->RUN if rounds left, else ->FINISH; FINISH->IDLE after one cycle.
REQ-014 SHALL latch cfg_base/cfg_beats/cfg_rounds on accepted start; start outside IDLE ignored.
REQ-015 SHALL, per round, reload each channel's address pointer and remaining-beat counter from latched config.
REQ-016 SHALL compute burst length = min(MAX_BURST, remaining, beats to next 4KB boundary); arlen_m = length-1.
REQ-017 SHALL track per-channel credit = free FIFO slots - outstanding beats; channel eligible only when remaining>0 and credit>=burst length.
REQ-018 SHALL arbitrate eligible channels round-robin, starting after last granted channel; channel 0 first after reset.
REQ-019 SHALL hold arvalid_m, araddr_m, arlen_m, arid_m stable until arready_m; no re-arbitration while pending.
REQ-020 SHALL drive arsize_m = 3'b110, arid_m = channel index zero-extended; arvalid_m = 0 outside RUN.
REQ-021 SHALL, on AR handshake, add length*64 to address, subtract length from remaining, add length to outstanding.
REQ-022 SHALL drive rready_m = 1 always; beat with rvalid_m writes rdata_m to FIFO[rid_m] and decrements its outstanding; rid_m >= N_CH beats dropped.
REQ-023 SHALL handle same-cycle issue, return and pop on one channel with all counters updated consistently.
REQ-024 SHALL drive out_valid[c] = FIFO c non-empty, out_data = FIFO head; pop on out_valid & out_ready.
REQ-025 SHALL skip channels with cfg_beats = 0; all-zero config completes each round in NEXT_ROUND without AR traffic.
REQ-026 SHALL assert busy in all non-IDLE states and pulse done in FINISH.
REQ-027 SHALL ignore rresp_m and rlast_m for flow control (beat counting only).

Reset
REQ-028 SHALL on rst: state IDLE, arvalid_m 0, arid_m/araddr_m/arlen_m 0, arsize_m 3'b110, busy 0, done 0, out_valid 0, FIFOs/counters cleared, arbiter pointer 0; rst mid-run aborts immediately, later late R beats dropped until next start.

Verification
REQ-029 N_CH=2, base {0x1000,0x0}, beats {20,5}, rounds 1, arready=1 -> bursts ch0 8,8,4 at 0x0,0x200,0x400; ch1 5 at 0x1000, interleaved RR; 25 beats out; one done pulse.
REQ-030 Base 0xFC0, beats 4 -> bursts len 1 at 0xFC0, len 3 at 0x1000 (4KB split).
REQ-031 out_ready=0 on ch0, beats 40, depth 16 -> at most 16 beats requested; no further AR until pops; no beat lost.
REQ-032 cfg_rounds 3, beats {2,2} -> addresses replay 3 times, 12 beats total, done once at end.
REQ-033 rst asserted with 6 beats outstanding -> next cycle arvalid_m 0, out_valid 0, busy 0; new start runs cleanly.
REQ-034 rvalid_m with rid_m=5 (N_CH=2) -> beat discarded, counters unchanged.
